vending_change_dispenser: RTL and testbench
===========================================

Name: vending_change_dispenser

Overview:
- Payout side of the vending machine coin path: takes a change amount in cents over a valid/ready request, then drives the coin-return mechanism one coin at a time, dimes first, then nickels.
- Each coin uses a level eject/ack handshake, with a programmable gap between coins and an ack timeout that latches a fault.
- Sits between the vending FSM (credit/overpay logic) and the physical coin-return actuator.

Parameters:
- CENTS_W, 8, width of the requested amount in cents.
- GAP_CYCLES, 2, idle cycles (both eject lines low) between consecutive coins; legal range 1..15.
- ACK_TIMEOUT, 16, max cycles an eject line may be held without ack before fault; legal range 2..255.

Ports:
- clk, input, 1, single clock; all state updates on posedge.
- rstn, input, 1, asynchronous active-low reset.
- req_valid, input, 1, change request present.
- req_cents, input, CENTS_W, amount of change in cents.
- req_ready, output, 1, block can accept a request.
- eject_n, output, 1, eject-one-nickel command, level.
- eject_d, output, 1, eject-one-dime command, level.
- eject_ack, input, 1, mechanism has ejected the commanded coin.
- busy, output, 1, payout in progress.
- done, output, 1, one-cycle pulse: payout complete.
- err, output, 1, one-cycle pulse: req_cents not a multiple of 5.
- fault, output, 1, sticky: ack timeout; cleared only by rstn.

Behaviour:
- Reset: while rstn=0, all outputs are forced 0 asynchronously and the FSM enters IDLE. req_ready rises on the first clock edge after release. Reset mid-payout abandons the remaining coins.
- All outputs are registered/Moore, decoded from the state.
- States: IDLE, EJECT, GAP, DONE, FAULT.
- Outputs by state:
  - req_ready=1 only in IDLE.
  - busy=1 in EJECT, GAP and DONE.
  - eject_d=1 in EJECT when the current coin is a dime; eject_n=1 in EJECT when it is a nickel.
  - eject_d and eject_n are never high together.
- IDLE:
  - Acceptance happens on the edge where req_valid&req_ready=1.
  - Capture rem = req_cents rounded down to a multiple of 5; the remainder is discarded.
  - err pulses in the next cycle if req_cents mod 5 != 0.
  - If rem=0, go to DONE; otherwise go to EJECT.
  - req_cents is ignored outside acceptance.
- Coin selection, fixed on entry to EJECT: dime if rem>=10, else nickel.
- EJECT:
  - The eject line is held high until eject_ack is sampled 1.
  - On the ack edge, rem decrements by 10 or 5 (never underflows). Go to DONE if the new rem=0, else to GAP.
  - An ack_cnt counts EJECT cycles. If ack_cnt reaches ACK_TIMEOUT with no ack, go to FAULT.
  - eject_ack seen outside EJECT is ignored.
- GAP: exactly GAP_CYCLES cycles with both eject lines low, then EJECT for the next coin.
- DONE: done=1 for exactly one cycle, then IDLE.
- FAULT:
  - fault=1 and the eject lines are 0.
  - req_ready=0 and busy=0.
  - The block is locked until rstn.
- Latency, request accepted at edge k:
  - First eject is high in cycle k+1.
  - If rem=0, done is high in cycle k+1.
  - Last ack at edge m gives done in cycle m+1.
- Coin count for rem=R: R/10 dimes, plus one nickel iff R mod 10 = 5.
- A request presented while busy is held by the requester (not dropped); it is accepted only when IDLE returns.

Test Plan:
- req_cents=15, ack 1 cycle after each eject rise → eject_d pulse, then GAP_CYCLES=2 low cycles, then eject_n pulse. done pulses the cycle after the second ack; err=0.
- req_cents=0 → req_ready low for one cycle, done=1 in cycle k+1, no eject activity, err=0.
- req_cents=23 → err pulse in cycle k+1. Payout is exactly 2 dimes (rem 20→10→0), no nickel, then done.
- req_cents=30 with eject_ack held 0 → eject_d held high 16 cycles, then fault=1, eject_d=0, req_ready=0. A new req_valid is not accepted until rstn.
- req_cents=40, rstn asserted during the second EJECT → eject_d=0 immediately (asynchronous). After release: req_ready=1, rem discarded, no further ejects.
- req_valid held with req_cents=10 during an active 25-cent payout → second request accepted only in IDLE after done. Totals: 3 dimes and 1 nickel, two done pulses.

Source files
------------

// File: rtl/vending_change_dispenser.sv
// Coin-return payout engine: accepts a change amount and ejects dimes, then nickels,
// one coin per eject/ack handshake, with an inter-coin gap and a sticky ack-timeout fault.
module vending_change_dispenser #(
  parameter int CENTS_W     = 8,
  parameter int GAP_CYCLES  = 2,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               req_valid,
  input  logic [CENTS_W-1:0] req_cents,
  output logic               req_ready,
  output logic               eject_n,
  output logic               eject_d,
  input  logic               eject_ack,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               fault
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    EJECT = 3'd1,
    GAP   = 3'd2,
    DONE  = 3'd3,
    FAULT = 3'd4
  } state_t;

  localparam logic [CENTS_W-1:0] FIVE_C   = CENTS_W'(5);
  localparam logic [CENTS_W-1:0] DIME_C   = CENTS_W'(10);
  localparam logic [CENTS_W-1:0] ZERO_C   = CENTS_W'(0);
  localparam logic [7:0]         ACK_LAST = 8'(ACK_TIMEOUT - 1);
  localparam logic [3:0]         GAP_LAST = 4'(GAP_CYCLES - 1);

  state_t             state_r;
  logic [CENTS_W-1:0] rem_r;
  logic               dime_r;
  logic [7:0]         ack_cnt_r;
  logic [3:0]         gap_cnt_r;

  logic [CENTS_W-1:0] mod5_s;
  logic [CENTS_W-1:0] accept_rem_s;
  logic [CENTS_W-1:0] rem_next_s;

  assign mod5_s       = req_cents % FIVE_C;
  assign accept_rem_s = req_cents - mod5_s;

  // Remaining amount after the coin currently being ejected; saturates at zero.
  always_comb begin
    rem_next_s = ZERO_C;
    if (dime_r) begin
      if (rem_r >= DIME_C) begin
        rem_next_s = rem_r - DIME_C;
      end else begin
        rem_next_s = ZERO_C;
      end
    end else begin
      if (rem_r >= FIVE_C) begin
        rem_next_s = rem_r - FIVE_C;
      end else begin
        rem_next_s = ZERO_C;
      end
    end
  end

  // Payout FSM; every output is registered and updated together with the state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r   <= IDLE;
      rem_r     <= ZERO_C;
      dime_r    <= 1'b0;
      ack_cnt_r <= 8'd0;
      gap_cnt_r <= 4'd0;
      req_ready <= 1'b0;
      eject_d   <= 1'b0;
      eject_n   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      fault     <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req_valid && req_ready) begin
            rem_r     <= accept_rem_s;
            err       <= (mod5_s != ZERO_C);
            req_ready <= 1'b0;
            busy      <= 1'b1;
            ack_cnt_r <= 8'd0;
            if (accept_rem_s == ZERO_C) begin
              state_r <= DONE;
              done    <= 1'b1;
            end else begin
              state_r <= EJECT;
              dime_r  <= (accept_rem_s >= DIME_C);
              eject_d <= (accept_rem_s >= DIME_C);
              eject_n <= (accept_rem_s < DIME_C);
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        EJECT: begin
          if (eject_ack) begin
            rem_r     <= rem_next_s;
            eject_d   <= 1'b0;
            eject_n   <= 1'b0;
            ack_cnt_r <= 8'd0;
            if (rem_next_s == ZERO_C) begin
              state_r <= DONE;
              done    <= 1'b1;
            end else begin
              state_r   <= GAP;
              gap_cnt_r <= 4'd0;
            end
          end else if (ack_cnt_r == ACK_LAST) begin
            state_r <= FAULT;
            eject_d <= 1'b0;
            eject_n <= 1'b0;
            busy    <= 1'b0;
            fault   <= 1'b1;
          end else begin
            ack_cnt_r <= ack_cnt_r + 8'd1;
          end
        end
        GAP: begin
          if (gap_cnt_r == GAP_LAST) begin
            state_r   <= EJECT;
            ack_cnt_r <= 8'd0;
            dime_r    <= (rem_r >= DIME_C);
            eject_d   <= (rem_r >= DIME_C);
            eject_n   <= (rem_r < DIME_C);
          end else begin
            gap_cnt_r <= gap_cnt_r + 4'd1;
          end
        end
        DONE: begin
          state_r   <= IDLE;
          busy      <= 1'b0;
          req_ready <= 1'b1;
        end
        FAULT: begin
          // Locked until rstn; hold every output in its safe value.
          state_r   <= FAULT;
          req_ready <= 1'b0;
          busy      <= 1'b0;
          eject_d   <= 1'b0;
          eject_n   <= 1'b0;
          fault     <= 1'b1;
        end
        default: begin
          state_r   <= IDLE;
          req_ready <= 1'b0;
          busy      <= 1'b0;
          eject_d   <= 1'b0;
          eject_n   <= 1'b0;
          fault     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vending_change_dispenser.sv
// Directed bench for vending_change_dispenser: a scoreboard queue of expected coins/done
// events filled on request acceptance, drained as the DUT ejects coins and pulses done.
module tb_vending_change_dispenser;

  localparam int CENTS_W     = 8;
  localparam int GAP_CYCLES  = 2;
  localparam int ACK_TIMEOUT = 16;

  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic               req_valid = 1'b0;
  logic [CENTS_W-1:0] req_cents = '0;
  logic               eject_ack = 1'b0;
  logic               req_ready, eject_n, eject_d, busy, done, err, fault;

  vending_change_dispenser #(
    .CENTS_W(CENTS_W), .GAP_CYCLES(GAP_CYCLES), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_cents(req_cents),
    .req_ready(req_ready), .eject_n(eject_n), .eject_d(eject_d),
    .eject_ack(eject_ack), .busy(busy), .done(done), .err(err), .fault(fault)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int exp_q[$];            // 0 = nickel, 1 = dime, 2 = done
  bit ack_en = 1'b1;
  int ack_delay = 1;
  int hi_cnt = 0;
  int dimes = 0, nickels = 0, dones = 0, rises = 0;
  bit prev_ej = 1'b0;
  int low_run = 0;
  bit first_coin = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag, input int obs);
    if (exp_q.size() == 0) check(tag, obs, 99);
    else check(tag, obs, exp_q.pop_front());
  endtask

  // One clock: note acceptance/ack before the edge, sample #1 after it, then act as the mechanism.
  task automatic step();
    bit acc, ack_edge, acc_zero;
    int c, r;
    acc      = (req_valid === 1'b1) && (req_ready === 1'b1);
    ack_edge = (eject_ack === 1'b1) && ((eject_d | eject_n) === 1'b1);
    c        = int'(req_cents);
    acc_zero = 1'b0;
    @(posedge clk);
    #1;
    if (acc) begin
      check("accept_while_pending", exp_q.size(), 0);
      r = c - (c % 5);
      for (int i = 0; i < r / 10; i++) exp_q.push_back(1);
      if (r % 10 == 5) exp_q.push_back(0);
      exp_q.push_back(2);
      check("err_pulse", err, (c % 5) != 0);
      check("first_eject_latency", eject_d | eject_n, r != 0);
      acc_zero   = (r == 0);
      first_coin = 1'b1;
      req_valid  = 1'b0;
    end else begin
      check("err_quiet", err, 0);
    end
    check("eject_exclusive", eject_d & eject_n, 0);
    if ((eject_d | eject_n) && !prev_ej) begin
      rises++;
      if (!first_coin) check("gap_len", low_run, GAP_CYCLES);
      first_coin = 1'b0;
      pop_check("coin", eject_d ? 1 : 0);
      if (eject_d) dimes++;
      else nickels++;
    end
    if (done) begin
      dones++;
      check("done_latency", acc_zero || ack_edge, 1);
      pop_check("done", 2);
    end
    low_run = (eject_d | eject_n) ? 0 : low_run + 1;
    prev_ej = eject_d | eject_n;
    if ((eject_d | eject_n) && ack_en) begin
      hi_cnt++;
      eject_ack = (hi_cnt > ack_delay);
    end else begin
      hi_cnt    = 0;
      eject_ack = 1'b0;
    end
  endtask

  task automatic wait_dones(input int target, input int budget);
    for (int i = 0; i < budget && dones < target; i++) step();
    check("done_reached", dones >= target, 1);
  endtask

  task automatic do_reset();
    #2;
    rstn = 1'b0;
    #1;
    check("reset_async", {req_ready, busy, done, err, fault, eject_d, eject_n}, 0);
    exp_q.delete();
    first_coin = 1'b1;
    prev_ej    = 1'b0;
    low_run    = 0;
    hi_cnt     = 0;
    eject_ack  = 1'b0;
    #2;
    rstn = 1'b1;
    step();
    check("ready_after_reset", req_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, n0, dd0, r0;
    #1;
    check("reset_outputs", {req_ready, busy, done, err, fault, eject_d, eject_n}, 0);
    #11;
    rstn = 1'b1;
    step();
    check("ready_first_edge", req_ready, 1);

    // 15 cents: dime, gap, nickel, done
    d0 = dimes; n0 = nickels; dd0 = dones;
    req_cents = 8'd15; req_valid = 1'b1;
    step();
    check("busy_on_accept", busy, 1);
    wait_dones(dd0 + 1, 60);
    check("c15_dimes", dimes - d0, 1);
    check("c15_nickels", nickels - n0, 1);
    step();
    check("c15_ready_back", req_ready, 1);

    // 0 cents: done right away, no coins
    r0 = rises; dd0 = dones;
    req_cents = 8'd0; req_valid = 1'b1;
    step();
    check("c0_ready_low", req_ready, 0);
    check("c0_done", done, 1);
    step();
    check("c0_ready_high", req_ready, 1);
    check("c0_no_eject", rises - r0, 0);

    // 23 cents: err pulse, two dimes
    d0 = dimes; n0 = nickels; dd0 = dones;
    req_cents = 8'd23; req_valid = 1'b1;
    step();
    wait_dones(dd0 + 1, 60);
    check("c23_dimes", dimes - d0, 2);
    check("c23_nickels", nickels - n0, 0);
    step();

    // 30 cents with no ack: timeout into sticky fault
    ack_en = 1'b0;
    req_cents = 8'd30; req_valid = 1'b1;
    step();
    for (int i = 0; i < ACK_TIMEOUT - 1; i++) begin
      step();
      check("timeout_eject_held", eject_d, 1);
    end
    step();
    check("fault_set", fault, 1);
    check("fault_eject_low", eject_d | eject_n, 0);
    check("fault_ready_low", req_ready, 0);
    check("fault_busy_low", busy, 0);
    exp_q.delete();
    req_cents = 8'd10; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("fault_locked", {fault, req_ready, busy}, 3'b100);
    end
    check("fault_req_held", req_valid, 1);
    req_valid = 1'b0;
    ack_en = 1'b1;
    do_reset();

    // 40 cents, reset during the second eject
    r0 = rises;
    req_cents = 8'd40; req_valid = 1'b1;
    step();
    for (int i = 0; i < 40 && rises < r0 + 2; i++) step();
    check("second_eject_seen", rises - r0, 2);
    check("second_eject_high", eject_d, 1);
    do_reset();
    for (int i = 0; i < 6; i++) step();
    check("no_eject_after_reset", rises - r0, 2);
    check("idle_after_reset", {req_ready, busy}, 2'b10);

    // 25 cents with a 10-cent request held during the payout
    d0 = dimes; n0 = nickels; dd0 = dones;
    req_cents = 8'd25; req_valid = 1'b1;
    step();
    req_cents = 8'd10; req_valid = 1'b1;
    step();
    check("held_not_accepted", req_valid, 1);
    wait_dones(dd0 + 2, 120);
    check("held_accepted", req_valid, 0);
    check("tot_dimes", dimes - d0, 3);
    check("tot_nickels", nickels - n0, 1);
    check("tot_dones", dones - dd0, 2);
    step();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
